sprite_frame_buffer: RTL
========================

# sprite_frame_buffer

Double-buffered frame buffer: the responder on the `fb_*` interface driven by `sprite_command_controller`. Pixel writes go to the back buffer. A display request (`fb_dfb`) swaps front and back at the next vertical-blank pulse, then clears the new back buffer to black. A separate read port serves the VGA scan-out path from the front buffer.

## Interface
Parameters:
- `PX_W`, 16: pixel address width; each bank holds 2^PX_W pixels, addressed as {x[7:0], y[7:0]}.
- `COLOR_W`, 8: width of each colour channel; a stored pixel is 3*COLOR_W bits, packed {r,g,b}.
- `CLEAR_ON_SWAP`, 1: when 1, the new back buffer is cleared after each swap; when 0, the clear phase is skipped.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain); the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `fb_wfb`  in  1  write-pixel strobe; one pixel per cycle.
- `fb_dfb`  in  1  display-frame strobe; requests a buffer swap.
- `fb_px`  in  PX_W  write pixel address.
- `fb_r`, `fb_g`, `fb_b`  in  COLOR_W each  write colour.
- `fb_busy`  out  1  high while a swap is pending or a clear is running; writes and swap requests are not accepted.
- `vblank`  in  1  one-cycle pulse at the start of vertical blank, from VGA timing.
- `rd_en`  in  1  scan-out read request.
- `rd_px`  in  PX_W  scan-out read address.
- `rd_rgb`  out  3*COLOR_W  read data from the front buffer.
- `rd_valid`  out  1  `rd_rgb` is valid this cycle.
- `front_sel`  out  1  index of the current front bank.
- `wr_drop`  out  1  sticky error: a write or swap request arrived while busy. Cleared only by `rst`.

## Operation
- Storage: two banks, bank0 and bank1. Back bank = `~front_sel`.
- States:
  - IDLE: `fb_wfb` writes {r,g,b} to the back bank at `fb_px`. `fb_dfb` moves to SWAP_WAIT.
  - SWAP_WAIT: wait for `vblank`. On `vblank`, toggle `front_sel`, then go to CLEAR if CLEAR_ON_SWAP=1, else to IDLE.
  - CLEAR: a PX_W-bit counter writes 0 to the back bank at addresses 0 .. 2^PX_W-1, one per cycle. On the final address, go to IDLE.
- `fb_busy` = (state != IDLE).
- Same-cycle `fb_wfb` and `fb_dfb` in IDLE: the write lands in the current back bank, then the FSM enters SWAP_WAIT.
- `fb_wfb` or `fb_dfb` while busy: the request is ignored, memory is unchanged, and `wr_drop` is set.
- `vblank` in IDLE or CLEAR: no effect.
- `vblank` in the same cycle as the `fb_dfb` that enters SWAP_WAIT: no swap. The FSM waits for the next `vblank`.
- Reads always come from the bank selected by `front_sel` in the request cycle. Reads never stall and are never blocked by writes, the swap, or the clear.
- Reset values: state IDLE, `front_sel`=0, `fb_busy`=0, `rd_valid`=0, `rd_rgb`=0, `wr_drop`=0, clear counter 0.
- Memory contents are not affected by `rst`.
- Reset during CLEAR: the FSM returns to IDLE and the back bank stays partially cleared. This is accepted behaviour.

## Timing
- Write: data is visible to a read of the same bank issued 1 cycle later. A same-address read in the same cycle returns old data.
- Read latency is 1 cycle: `rd_en` at cycle N gives `rd_valid`=1 and `rd_rgb` at N+1.
- `rd_valid` is 0 in any cycle following `rd_en`=0; `rd_rgb` holds its last value.
- Swap sequence:
  - `fb_dfb` at N: `fb_busy`=1 from N+1.
  - `vblank` at M > N: `front_sel` toggles at M+1.
  - CLEAR occupies cycles M+1 .. M+2^PX_W.
  - `fb_busy`=0 from M+2^PX_W+1.
- With CLEAR_ON_SWAP=0: `fb_busy`=0 from M+1.
- Sustained throughput: one write and one read per cycle.

## Structure
- Package `sprite_fb_pkg`:
  - state enum `fb_state_t` {FB_IDLE, FB_SWAP_WAIT, FB_CLEAR};
  - `FB_PIXEL_W` = 3*COLOR_W default;
  - `FB_BLACK` constant.
- Sub-module `fb_bank`: simple dual-port RAM with one write port and one registered read port, 1-cycle latency, inferable as M10K. Instantiated twice.
- Top level contains:
  - the FSM;
  - the clear counter;
  - the write mux, which selects between pixel write and clear write and is steered to the back bank;
  - the read-data mux, which selects using a registered copy of `front_sel`.

## Test plan
- Reset, then `rd_en` at px 0 → `rd_valid`=1 next cycle; `front_sel`=0, `fb_busy`=0, `wr_drop`=0.
- Write px 16'h1020 with RGB 0xFF/0x00/0x00, `fb_dfb`, `vblank` → `front_sel`=1 and a read of px 16'h1020 returns 24'hFF0000. After the clear, `fb_busy` falls exactly 65536 cycles after the swap.
- `fb_wfb` at px 5 during SWAP_WAIT → write ignored and `wr_drop`=1. After the swap, a read of px 5 from the front buffer returns its prior value.
- Same-cycle `fb_wfb` and `fb_dfb` → the pixel appears in the front buffer after `vblank`.
- `vblank` asserted in IDLE → `front_sel` unchanged. `vblank` in the same cycle as `fb_dfb` → no swap until the next `vblank`.
- `rst` pulse 100 cycles into CLEAR → state IDLE, `fb_busy`=0, `front_sel`=0 on the next cycle. A new `fb_wfb` is accepted immediately.

Source files
------------

// File: rtl/sprite_fb_pkg.sv
// rtl/sprite_fb_pkg.sv - shared types and constants for the sprite frame buffer
package sprite_fb_pkg;

    localparam int FB_COLOR_W = 8;
    localparam int FB_PIXEL_W = 3 * FB_COLOR_W;
    localparam logic [FB_PIXEL_W-1:0] FB_BLACK = '0;

    typedef enum logic [1:0] {
        FB_IDLE,
        FB_SWAP_WAIT,
        FB_CLEAR
    } fb_state_t;

endpackage

// File: rtl/fb_bank.sv
// rtl/fb_bank.sv - simple dual-port pixel bank, one write port, registered read port
module fb_bank #(
    parameter int AW = 16,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register clears on reset; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sprite_frame_buffer.sv
// rtl/sprite_frame_buffer.sv - double-buffered frame buffer with vblank swap and back-buffer clear
module sprite_frame_buffer
    import sprite_fb_pkg::*;
#(
    parameter int PX_W          = 16,
    parameter int COLOR_W       = 8,
    parameter bit CLEAR_ON_SWAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fb_wfb,
    input  logic                 fb_dfb,
    input  logic [PX_W-1:0]      fb_px,
    input  logic [COLOR_W-1:0]   fb_r,
    input  logic [COLOR_W-1:0]   fb_g,
    input  logic [COLOR_W-1:0]   fb_b,
    output logic                 fb_busy,
    input  logic                 vblank,
    input  logic                 rd_en,
    input  logic [PX_W-1:0]      rd_px,
    output logic [3*COLOR_W-1:0] rd_rgb,
    output logic                 rd_valid,
    output logic                 front_sel,
    output logic                 wr_drop
);

    localparam int PW = 3 * COLOR_W;

    fb_state_t       state_q, state_d;
    logic            front_q, front_d;
    logic [PX_W-1:0] clr_q, clr_d;
    logic            drop_q, drop_d;
    logic            rd_valid_q, rd_sel_q;

    logic            wr_en;
    logic [PX_W-1:0] wr_addr;
    logic [PW-1:0]   wr_data;
    logic [PW-1:0]   rdata0, rdata1;

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        clr_d   = clr_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        wr_addr = fb_px;
        wr_data = {fb_r, fb_g, fb_b};
        case (state_q)
            FB_IDLE: begin
                wr_en = fb_wfb;
                if (fb_dfb) begin
                    state_d = FB_SWAP_WAIT;
                end
            end
            FB_SWAP_WAIT: begin
                if (vblank) begin
                    front_d = ~front_q;
                    clr_d   = '0;
                    state_d = CLEAR_ON_SWAP ? FB_CLEAR : FB_IDLE;
                end
            end
            FB_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_q;
                wr_data = '0;
                clr_d   = clr_q + 1'b1;
                if (clr_q == {PX_W{1'b1}}) begin
                    state_d = FB_IDLE;
                end
            end
            default: state_d = FB_IDLE;
        endcase
        if (state_q != FB_IDLE && (fb_wfb || fb_dfb)) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FB_IDLE;
            front_q    <= 1'b0;
            clr_q      <= '0;
            drop_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            front_q    <= front_d;
            clr_q      <= clr_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_sel_q <= front_q;
            end
        end
    end

    // Writes always target the back bank, i.e. the one not selected by front_q.
    fb_bank #(.AW(PX_W), .DW(PW)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en & front_q),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_px),
        .rdata (rdata0)
    );

    fb_bank #(.AW(PX_W), .DW(PW)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en & ~front_q),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_px),
        .rdata (rdata1)
    );

    assign rd_rgb    = rd_sel_q ? rdata1 : rdata0;
    assign rd_valid  = rd_valid_q;
    assign front_sel = front_q;
    assign fb_busy   = (state_q != FB_IDLE);
    assign wr_drop   = drop_q;

endmodule
